// File: rtl/mips_mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the unified memory.
//   slave  : arbiter view (requests and mem_rdata in; acks, rdata, memory strobes and busy out)
//   master : environment view (requesters plus memory model)
interface mips_mem_port_arbiter_if #(
    parameter int unsigned AW = 10
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [31:0]   if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata;
    logic          d_ack;
    logic [31:0]   d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    logic          busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mips_mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch (requester 0,
// read-only) and MEM-stage data access (requester 1, load/store). Data has fixed
// priority; a starvation counter forces a fetch grant after STARVE_LIM data grants
// made while fetch was waiting. Each access runs IDLE -> ISSUE -> WAIT(MEM_LAT) -> RESP.
// Ports:
//   clk1  : single clock, all state changes on posedge
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of mips_mem_port_arbiter_if (requester handshakes,
//           memory strobes, busy)
module mips_mem_port_arbiter #(
    parameter int unsigned AW         = 10,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_LIM = 2
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    mips_mem_port_arbiter_if.slave   bus
);
    localparam int unsigned CW = 4;
    localparam int unsigned SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_wait_cnt;
    logic [SW-1:0] r_starve_cnt;
    logic          r_win_d;
    logic          r_we;

    logic          r_if_ack;
    logic [31:0]   r_if_rdata;
    logic          r_d_ack;
    logic [31:0]   r_d_rdata;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_busy;

    logic          w_starved;
    logic          w_grant_d;
    logic          w_grant_f;

    // Data wins unless fetch has been passed over STARVE_LIM times in a row.
    assign w_starved = (r_starve_cnt == SW'(STARVE_LIM));
    assign w_grant_d = bus.d_req && !(bus.if_req && w_starved);
    assign w_grant_f = bus.if_req && !w_grant_d;

    // Access sequencer with registered outputs; mem_en is set on the grant edge so it
    // is high exactly for the ISSUE cycle.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
            r_win_d      <= 1'b0;
            r_we         <= 1'b0;
            r_if_ack     <= 1'b0;
            r_if_rdata   <= '0;
            r_d_ack      <= 1'b0;
            r_d_rdata    <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_win_d     <= 1'b1;
                        r_we        <= bus.d_we;
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= bus.d_we;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                        // Count only grants that actually made fetch wait.
                        if (bus.if_req && !w_starved) begin
                            r_starve_cnt <= r_starve_cnt + SW'(1);
                        end
                    end else if (w_grant_f) begin
                        r_win_d      <= 1'b0;
                        r_we         <= 1'b0;
                        r_mem_addr   <= bus.if_addr;
                        r_mem_en     <= 1'b1;
                        r_busy       <= 1'b1;
                        r_starve_cnt <= '0;
                        r_state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_wait_cnt <= CW'(MEM_LAT);
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (r_wait_cnt == CW'(1)) begin
                        if (!r_we) begin
                            if (r_win_d) r_d_rdata  <= bus.mem_rdata;
                            else         r_if_rdata <= bus.mem_rdata;
                        end
                        r_d_ack  <= r_win_d;
                        r_if_ack <= !r_win_d;
                        r_state  <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CW'(1);
                    end
                end

                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mips_mem_port_arbiter.sv
// Directed bench: dut0 (MEM_LAT=2, STARVE_LIM=2) and dut1 (MEM_LAT=1), each with a
// behavioural fixed-latency memory.
module tb_mips_mem_port_arbiter;
    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk1 = ~clk1;

    mips_mem_port_arbiter_if #(.AW(10)) bus0 ();
    mips_mem_port_arbiter_if #(.AW(10)) bus1 ();

    mips_mem_port_arbiter #(.AW(10), .MEM_LAT(2), .STARVE_LIM(2)) dut0 (
        .clk1(clk1), .rst_n(rst_n), .bus(bus0)
    );
    mips_mem_port_arbiter #(.AW(10), .MEM_LAT(1), .STARVE_LIM(2)) dut1 (
        .clk1(clk1), .rst_n(rst_n), .bus(bus1)
    );

    function automatic logic [31:0] init0(input int a);
        return (a == 5) ? 32'h2800000A : (32'hC0DE0000 + 32'(a));
    endfunction
    function automatic logic [31:0] init1(input int a);
        return 32'h11110000 + 32'(a);
    endfunction

    // Memory models: read data sampled on the mem_en edge, presented MEM_LAT-1 edges later.
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    bit          mem_ready = 1'b0;
    logic [31:0] rd0_s0, rd0_s1, rd1_s0;

    always @(posedge clk1) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) begin
                mem0[i] <= init0(i);
                mem1[i] <= init1(i);
            end
            mem_ready <= 1'b1;
        end else begin
            if (bus0.mem_en && bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
            if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
        end
        if (bus0.mem_en) rd0_s0 <= mem0[bus0.mem_addr];
        rd0_s1 <= rd0_s0;
        if (bus1.mem_en) rd1_s0 <= mem1[bus1.mem_addr];
    end
    assign bus0.mem_rdata = rd0_s1;
    assign bus1.mem_rdata = rd1_s0;

    // Strobe spacing monitor for dut0.
    int cyc = 0;
    int last_en = -100;
    int spacing_viol = 0;
    always @(negedge clk1) begin
        cyc++;
        if (bus0.mem_en) begin
            if (cyc - last_en < 5) spacing_viol++;
            last_en = cyc;
        end
    end

    logic [31:0] exp_d_rdata;

    // which: 0 = dut0 fetch, 1 = dut0 data, 2 = dut1 fetch. cycles = -1 on timeout.
    task automatic wait_ack(input int which, output int cycles);
        cycles = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk1);
            if ((which == 0 && bus0.if_ack) || (which == 1 && bus0.d_ack) ||
                (which == 2 && bus1.if_ack)) begin
                cycles = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk1);
        @(negedge clk1);
        n_checks++;
        if ({bus0.if_ack, bus0.d_ack, bus0.if_rdata, bus0.d_rdata, bus0.mem_en, bus0.mem_we,
             bus0.mem_addr, bus0.mem_wdata, bus0.busy} !== '0) begin
            $display("FAIL reset_outputs: got if_ack=%b d_ack=%b mem_en=%b busy=%b, want all 0",
                     bus0.if_ack, bus0.d_ack, bus0.mem_en, bus0.busy);
            n_errors++;
        end
        n_checks++;
        if (dut0.r_starve_cnt !== '0) begin
            $display("FAIL reset_starve: got %0d want 0", dut0.r_starve_cnt);
            n_errors++;
        end
        rst_n = 1'b1;
        @(negedge clk1);
    endtask

    task automatic test_fetch_latency();
        bus0.if_addr = 10'd5;
        bus0.if_req  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk1);
            n_checks++;
            if (bus0.mem_en !== (k == 0) || bus0.busy !== (k <= 3) || bus0.if_ack !== (k == 3)) begin
                $display("FAIL fetch_timing k=%0d: got mem_en=%b busy=%b if_ack=%b want %b %b %b",
                         k, bus0.mem_en, bus0.busy, bus0.if_ack, k == 0, k <= 3, k == 3);
                n_errors++;
            end
            if (k == 0) begin
                n_checks++;
                if (bus0.mem_addr !== 10'd5 || bus0.mem_we !== 1'b0) begin
                    $display("FAIL fetch_addr: got addr=%h we=%b want 005 0", bus0.mem_addr, bus0.mem_we);
                    n_errors++;
                end
            end
            if (k == 3) begin
                n_checks++;
                if (bus0.if_rdata !== 32'h2800000A) begin
                    $display("FAIL fetch_rdata: got %h want 2800000a", bus0.if_rdata);
                    n_errors++;
                end
                bus0.if_req = 1'b0;
            end
        end
    endtask

    task automatic test_priority();
        int c;
        spacing_viol = 0;
        bus0.if_addr = 10'd12;
        bus0.d_addr  = 10'd8;
        bus0.d_we    = 1'b0;
        bus0.if_req  = 1'b1;
        bus0.d_req   = 1'b1;
        wait_ack(1, c);
        n_checks++;
        if (c !== 3 || bus0.if_ack !== 1'b0) begin
            $display("FAIL prio_data_first: got latency=%0d if_ack=%b want 3 0", c, bus0.if_ack);
            n_errors++;
        end
        exp_d_rdata = init0(8);
        n_checks++;
        if (bus0.d_rdata !== exp_d_rdata) begin
            $display("FAIL prio_d_rdata: got %h want %h", bus0.d_rdata, exp_d_rdata);
            n_errors++;
        end
        bus0.d_req = 1'b0;
        wait_ack(0, c);
        n_checks++;
        if (c !== 4 || bus0.if_rdata !== init0(12)) begin
            $display("FAIL prio_fetch_next: got latency=%0d rdata=%h want 4 %h", c, bus0.if_rdata, init0(12));
            n_errors++;
        end
        bus0.if_req = 1'b0;
        @(negedge clk1);
        n_checks++;
        if (spacing_viol !== 0) begin
            $display("FAIL prio_spacing: got %0d violations want 0", spacing_viol);
            n_errors++;
        end
    endtask

    task automatic test_starvation();
        bit order [6];
        bit want  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int n = 0;
        bus0.if_addr = 10'd30;
        bus0.d_addr  = 10'd20;
        bus0.d_we    = 1'b0;
        bus0.if_req  = 1'b1;
        bus0.d_req   = 1'b1;
        for (int i = 0; i < 100 && n < 6; i++) begin
            @(negedge clk1);
            if (bus0.d_ack) begin
                order[n] = 1'b1;
                n++;
            end else if (bus0.if_ack) begin
                order[n] = 1'b0;
                n++;
                n_checks++;
                if (dut0.r_starve_cnt !== '0) begin
                    $display("FAIL starve_clear: got %0d want 0", dut0.r_starve_cnt);
                    n_errors++;
                end
            end
        end
        bus0.if_req = 1'b0;
        bus0.d_req  = 1'b0;
        n_checks++;
        if (n !== 6) begin
            $display("FAIL starve_count: got %0d acks want 6", n);
            n_errors++;
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (order[i] !== want[i]) begin
                $display("FAIL starve_order[%0d]: got %s want %s", i,
                         order[i] ? "D" : "F", want[i] ? "D" : "F");
                n_errors++;
            end
        end
        exp_d_rdata = init0(20);
        n_checks++;
        if (bus0.d_rdata !== exp_d_rdata || bus0.if_rdata !== init0(30)) begin
            $display("FAIL starve_rdata: got d=%h if=%h want %h %h", bus0.d_rdata, bus0.if_rdata,
                     exp_d_rdata, init0(30));
            n_errors++;
        end
        @(negedge clk1);
    endtask

    task automatic test_store();
        int en_n = 0;
        int we_n = 0;
        int bad_we = 0;
        int c = -1;
        bus0.d_addr  = 10'h3FF;
        bus0.d_wdata = 32'hDEADBEEF;
        bus0.d_we    = 1'b1;
        bus0.d_req   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk1);
            if (bus0.mem_en) en_n++;
            if (bus0.mem_en && bus0.mem_we && bus0.mem_addr === 10'h3FF &&
                bus0.mem_wdata === 32'hDEADBEEF) we_n++;
            if (bus0.mem_we && !bus0.mem_en) bad_we++;
            if (bus0.d_ack) begin
                c = i;
                break;
            end
        end
        bus0.d_req = 1'b0;
        bus0.d_we  = 1'b0;
        n_checks++;
        if (c !== 3 || en_n !== 1 || we_n !== 1 || bad_we !== 0) begin
            $display("FAIL store_strobe: got latency=%0d en=%0d we=%0d stray_we=%0d want 3 1 1 0",
                     c, en_n, we_n, bad_we);
            n_errors++;
        end
        n_checks++;
        if (bus0.d_rdata !== exp_d_rdata) begin
            $display("FAIL store_rdata_kept: got %h want %h", bus0.d_rdata, exp_d_rdata);
            n_errors++;
        end
        @(negedge clk1);
        bus0.if_addr = 10'h3FF;
        bus0.if_req  = 1'b1;
        wait_ack(0, c);
        bus0.if_req = 1'b0;
        n_checks++;
        if (c !== 3 || bus0.if_rdata !== 32'hDEADBEEF) begin
            $display("FAIL store_readback: got latency=%0d rdata=%h want 3 deadbeef", c, bus0.if_rdata);
            n_errors++;
        end
        @(negedge clk1);
    endtask

    task automatic test_reset_abort();
        int acks = 0;
        int c;
        bus0.d_addr = 10'd40;
        bus0.d_we   = 1'b0;
        bus0.d_req  = 1'b1;
        @(negedge clk1);
        @(negedge clk1);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus0.if_ack, bus0.d_ack, bus0.if_rdata, bus0.d_rdata, bus0.mem_en, bus0.mem_we,
             bus0.mem_addr, bus0.mem_wdata, bus0.busy} !== '0) begin
            $display("FAIL abort_outputs: got busy=%b d_rdata=%h if_rdata=%h mem_addr=%h want all 0",
                     bus0.busy, bus0.d_rdata, bus0.if_rdata, bus0.mem_addr);
            n_errors++;
        end
        bus0.d_req = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk1);
            if (bus0.d_ack) acks++;
        end
        n_checks++;
        if (acks !== 0 || bus0.busy !== 1'b0) begin
            $display("FAIL abort_no_ack: got acks=%0d busy=%b want 0 0", acks, bus0.busy);
            n_errors++;
        end
        bus0.d_req = 1'b1;
        wait_ack(1, c);
        bus0.d_req = 1'b0;
        n_checks++;
        if (c !== 3 || bus0.d_rdata !== init0(40)) begin
            $display("FAIL abort_reissue: got latency=%0d rdata=%h want 3 %h", c, bus0.d_rdata, init0(40));
            n_errors++;
        end
        @(negedge clk1);
    endtask

    task automatic test_back_to_back();
        int c;
        bus1.if_addr = 10'd0;
        bus1.if_req  = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_ack(2, c);
            n_checks++;
            if (c !== ((n == 0) ? 2 : 3) || bus1.if_rdata !== init1(n)) begin
                $display("FAIL b2b[%0d]: got gap=%0d rdata=%h want %0d %h", n, c, bus1.if_rdata,
                         (n == 0) ? 2 : 3, init1(n));
                n_errors++;
            end
            bus1.if_addr = 10'(n + 1);
        end
        bus1.if_req = 1'b0;
        @(negedge clk1);
    endtask

    initial begin
        bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
        bus0.d_addr = '0;   bus0.d_wdata = '0;
        bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
        bus1.d_addr = '0;   bus1.d_wdata = '0;
        exp_d_rdata = '0;
        test_reset();
        test_fetch_latency();
        test_priority();
        test_starvation();
        test_store();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
